// File: rtl/count_display_2dig.sv
// Registers the 35->10 counter value and scans its tens/units digits onto an active-low 7-segment bus, with wrap flagging.
// Latency: Q_in -> q_reg 1 clock, q_reg -> seg/in_range/wrap_pulse 1 clock; no backpressure, a value is consumed every clock.
module count_display_2dig #(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Q_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       in_range,
    output logic       wrap_pulse,
    output logic [3:0] wrap_cnt
);

    localparam logic [15:0] REF_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_DASH = 7'b0111111;

    logic [5:0]  q_reg;
    logic [5:0]  q_prev;
    logic [15:0] ref_cnt;
    logic        sel;

    logic        valid;
    logic [1:0]  tens;
    logic [5:0]  units_full;
    logic [15:0] ref_nxt;
    logic        sel_nxt;
    logic [6:0]  seg_nxt;
    logic        wrap_hit;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_DASH;
        endcase
    endfunction

    always_comb begin
        valid      = 1'b0;
        tens       = 2'd1;
        units_full = 6'd0;
        ref_nxt    = ref_cnt + 16'd1;
        sel_nxt    = sel;
        seg_nxt    = SEG_DASH;
        wrap_hit   = 1'b0;

        // Unknown bits must decode as invalid rather than leak X to the display.
        if (!$isunknown(q_reg) && q_reg >= 6'd10 && q_reg <= 6'd35)
            valid = 1'b1;

        if (q_reg >= 6'd30) begin
            tens       = 2'd3;
            units_full = q_reg - 6'd30;
        end else if (q_reg >= 6'd20) begin
            tens       = 2'd2;
            units_full = q_reg - 6'd20;
        end else begin
            tens       = 2'd1;
            units_full = q_reg - 6'd10;
        end

        if (ref_cnt == REF_LAST) begin
            ref_nxt = 16'd0;
            sel_nxt = ~sel;
        end

        // seg is decoded against the upcoming sel so digit and enable change together.
        if (valid)
            seg_nxt = sel_nxt ? seg_code({2'b00, tens}) : seg_code(units_full[3:0]);

        if (q_prev == 6'd10 && q_reg == 6'd35)
            wrap_hit = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg      <= 6'd0;
            q_prev     <= 6'd0;
            ref_cnt    <= 16'd0;
            sel        <= 1'b0;
            seg        <= SEG_DASH;
            an         <= 2'b10;
            in_range   <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= 4'd0;
        end else begin
            q_reg      <= Q_in;
            q_prev     <= q_reg;
            ref_cnt    <= ref_nxt;
            sel        <= sel_nxt;
            seg        <= seg_nxt;
            an         <= sel_nxt ? 2'b01 : 2'b10;
            in_range   <= valid;
            wrap_pulse <= wrap_hit;
            if (wrap_hit)
                wrap_cnt <= wrap_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_count_display_2dig.sv
// Directed bench for count_display_2dig with REFRESH_DIV=4.
module tb_count_display_2dig;

    logic       clk;
    logic       rst;
    logic [5:0] Q_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic       in_range;
    logic       wrap_pulse;
    logic [3:0] wrap_cnt;

    int checks;
    int errors;
    int pulses;
    logic [3:0] cnt_hist [0:16];

    localparam logic [6:0] DASH = 7'b0111111;

    count_display_2dig #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .Q_in(Q_in), .seg(seg), .an(an),
        .in_range(in_range), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return DASH;
        endcase
    endfunction

    // One rising edge, then settle on the falling edge; records any wrap pulse seen.
    task automatic tick();
        @(negedge clk);
        if (wrap_pulse === 1'b1) begin
            pulses++;
            if (pulses <= 16) cnt_hist[pulses] = wrap_cnt;
        end
    endtask

    task automatic apply_reset(input logic [5:0] v);
        rst = 1'b1;
        Q_in = v;
        tick();
        tick();
        rst = 1'b0;
        pulses = 0;
    endtask

    task automatic test_reset();
        logic [6:0] exp_seg;
        logic [1:0] exp_an;
        rst = 1'b1;
        Q_in = 6'd23;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (seg !== DASH || an !== 2'b10 || in_range !== 1'b0 || wrap_pulse !== 1'b0 || wrap_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold: seg=%b an=%b rng=%b pulse=%b cnt=%0d, want seg=%b an=10 rng=0 pulse=0 cnt=0",
                         seg, an, in_range, wrap_pulse, wrap_cnt, DASH);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            tick();
            if (n == 1) begin
                exp_seg = DASH; exp_an = 2'b10;
            end else if (n >= 4 && n <= 7) begin
                exp_seg = 7'b0100100; exp_an = 2'b01;
            end else begin
                exp_seg = 7'b0110000; exp_an = 2'b10;
            end
            checks++;
            if (seg !== exp_seg || an !== exp_an) begin
                errors++;
                $display("FAIL reset_scan edge %0d: seg=%b an=%b, want seg=%b an=%b", n, seg, an, exp_seg, exp_an);
            end
        end
    endtask

    task automatic test_countdown();
        int v_prev;
        int v;
        logic       exp_sel;
        logic [6:0] exp_seg;
        rst = 1'b1;
        Q_in = 6'd35;
        tick();
        tick();
        rst = 1'b0;
        v_prev = 0;
        for (int n = 1; n <= 30; n++) begin
            v = (n <= 26) ? 35 - (n - 1) : 10;
            Q_in = 6'(v);
            tick();
            if (n >= 2) begin
                exp_sel = ((n / 4) % 2) == 1;
                exp_seg = exp_sel ? code(v_prev / 10) : code(v_prev % 10);
                checks++;
                if (in_range !== 1'b1 || seg !== exp_seg || an !== (exp_sel ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL countdown edge %0d val %0d: rng=%b seg=%b an=%b, want rng=1 seg=%b an=%b",
                             n, v_prev, in_range, seg, an, exp_seg, exp_sel ? 2'b01 : 2'b10);
                end
            end
            v_prev = v;
        end
    endtask

    task automatic test_wrap();
        apply_reset(6'd11);
        Q_in = 6'd11; tick();
        Q_in = 6'd10; tick();
        Q_in = 6'd35; tick();
        checks++;
        if (wrap_pulse !== 1'b0 || wrap_cnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap_early: pulse=%b cnt=%0d, want pulse=0 cnt=0", wrap_pulse, wrap_cnt);
        end
        Q_in = 6'd34; tick();
        checks++;
        if (wrap_pulse !== 1'b1 || wrap_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wrap_edge: pulse=%b cnt=%0d, want pulse=1 cnt=1", wrap_pulse, wrap_cnt);
        end
        tick();
        checks++;
        if (wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL wrap_width: pulse=%b, want 0", wrap_pulse);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (pulses !== 1 || wrap_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wrap_total: pulses=%0d cnt=%0d, want pulses=1 cnt=1", pulses, wrap_cnt);
        end
    endtask

    task automatic test_sixteen_wraps();
        apply_reset(6'd20);
        for (int i = 0; i < 16; i++) begin
            Q_in = 6'd10; tick();
            Q_in = 6'd35; tick();
        end
        Q_in = 6'd34;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pulses !== 16) begin
            errors++;
            $display("FAIL wrap16_pulses: pulses=%0d, want 16", pulses);
        end
        checks++;
        if (pulses >= 16 && (cnt_hist[1] !== 4'd1 || cnt_hist[15] !== 4'd15 || cnt_hist[16] !== 4'd0)) begin
            errors++;
            $display("FAIL wrap16_count: cnt@1=%0d cnt@15=%0d cnt@16=%0d, want 1 15 0",
                     cnt_hist[1], cnt_hist[15], cnt_hist[16]);
        end
        checks++;
        if (wrap_cnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap16_final: cnt=%0d, want 0", wrap_cnt);
        end
    endtask

    task automatic test_out_of_range();
        logic [5:0] vals [0:3];
        logic       saw_tens;
        logic       saw_units;
        vals[0] = 6'd9;
        vals[1] = 6'd36;
        vals[2] = 6'd63;
        vals[3] = 6'bxxxxxx;
        for (int k = 0; k < 4; k++) begin
            Q_in = vals[k];
            tick();
            tick();
            saw_tens = 1'b0;
            saw_units = 1'b0;
            for (int i = 0; i < 9; i++) begin
                tick();
                if (an === 2'b01) saw_tens = 1'b1;
                if (an === 2'b10) saw_units = 1'b1;
                checks++;
                if (in_range !== 1'b0 || seg !== DASH) begin
                    errors++;
                    $display("FAIL out_of_range case %0d: rng=%b seg=%b an=%b, want rng=0 seg=%b", k, in_range, seg, an, DASH);
                end
            end
            checks++;
            if (!(saw_tens && saw_units)) begin
                errors++;
                $display("FAIL oor_scan case %0d: tens_seen=%b units_seen=%b, want 1 1", k, saw_tens, saw_units);
            end
        end
        pulses = 0;
        Q_in = 6'd10; tick();
        Q_in = 6'd36; tick();
        Q_in = 6'd35; tick();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL no_wrap_via_36: pulses=%0d, want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        pulses = 0;
        Q_in = 6'd20; tick();
        Q_in = 6'd35; tick();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL no_wrap_from_20: pulses=%0d, want 0", pulses);
        end
    endtask

    task automatic test_reset_vs_wrap();
        apply_reset(6'd12);
        Q_in = 6'd10; tick();
        Q_in = 6'd35; tick();
        Q_in = 6'd10; tick();
        Q_in = 6'd35; tick();
        checks++;
        if (wrap_cnt !== 4'd1) begin
            errors++;
            $display("FAIL rvw_setup: cnt=%0d, want 1", wrap_cnt);
        end
        tick();
        rst = 1'b1;
        Q_in = 6'd10; tick();
        Q_in = 6'd35; tick();
        tick();
        checks++;
        if (wrap_pulse !== 1'b0 || wrap_cnt !== 4'd0 || an !== 2'b10) begin
            errors++;
            $display("FAIL rvw_in_reset: pulse=%b cnt=%0d an=%b, want pulse=0 cnt=0 an=10", wrap_pulse, wrap_cnt, an);
        end
        // Repeat the pair so the edge carrying 10->35 detection coincides with rst.
        rst = 1'b0;
        Q_in = 6'd10; tick();
        Q_in = 6'd35; tick();
        rst = 1'b1;
        tick();
        checks++;
        if (wrap_pulse !== 1'b0 || wrap_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rvw_same_cycle: pulse=%b cnt=%0d, want pulse=0 cnt=0", wrap_pulse, wrap_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (an !== 2'b10 || wrap_pulse !== 1'b0 || wrap_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rvw_release: an=%b pulse=%b cnt=%0d, want an=10 pulse=0 cnt=0", an, wrap_pulse, wrap_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulses = 0;
        for (int i = 0; i <= 16; i++) cnt_hist[i] = 4'd0;
        rst = 1'b1;
        Q_in = 6'd0;
        test_reset();
        test_countdown();
        test_wrap();
        test_sixteen_wraps();
        test_out_of_range();
        test_back_to_back();
        test_reset_vs_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
